// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
//   Shared definitions for the systolic operand feeder and its lane selector.
//   - Default array geometry and operand width.
//   - Width helpers: accumulator width for consumers, step-counter width.
//   - Feeder FSM state encoding.
//   - Index helpers for the flattened matrix / lane buses.
// ---------------------------------------------------------------------------
package systolic_pkg;

    localparam int DEF_N      = 2;
    localparam int DEF_DATA_W = 8;

    // Accumulator width a PE needs to hold an N-term dot product of
    // DATA_W-bit signed operands without overflow.
    function automatic int acc_w(input int data_w, input int n);
        return 2 * data_w + $clog2(n) + 1;
    endfunction

    localparam int DEF_ACC_W = acc_w(DEF_DATA_W, DEF_N);

    // Step counter spans 0 .. 3N-3.
    function automatic int t_w(input int n);
        return $clog2(3 * n - 1);
    endfunction

    // LSB of element (row, col) in a row-major flattened N x N matrix bus.
    function automatic int elem_lsb(input int row, input int col, input int n, input int data_w);
        return (row * n + col) * data_w;
    endfunction

    // LSB of lane number 'lane' in a flattened lane bus.
    function automatic int lane_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/systolic_operand_feeder_skew_lane_sel.sv
// ---------------------------------------------------------------------------
// skew_lane_sel
//   Picks the operand that one edge lane of the systolic array must carry
//   at step t. Lane 'lane' is delayed by 'lane' steps, so at step t it
//   carries operand k = t - lane when 0 <= k < N, otherwise zero.
//
//   ops  : the N operands of this lane, operand k at [k*DATA_W +: DATA_W]
//   lane : lane index (row index for A lanes, column index for B lanes)
//   t    : current stream step
//   sel  : selected operand, or 0 outside the lane's window
// ---------------------------------------------------------------------------
module skew_lane_sel
    import systolic_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int T_W    = t_w(N)
) (
    input  logic [N*DATA_W-1:0] ops,
    input  logic [T_W-1:0]      lane,
    input  logic [T_W-1:0]      t,
    output logic [DATA_W-1:0]   sel
);

    // Matching t == lane + k avoids a signed subtraction; lane + k never
    // exceeds 2N-2, which always fits in T_W bits.
    always_comb begin
        sel = '0;
        for (int k = 0; k < N; k++) begin
            if (t == lane + T_W'(k)) begin
                sel = ops[lane_lsb(k, DATA_W) +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/systolic_operand_feeder.sv
// ---------------------------------------------------------------------------
// systolic_operand_feeder
//   Accepts one A/B signed matrix pair, clears the downstream MAC array for
//   one cycle, streams diagonally skewed operands into the array's row (A)
//   and column (B) edges, zero-pads while the array drains and then pulses
//   done when every PE accumulator holds its final dot product.
//
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (abandons any job, no done)
//   in_valid : matrix pair offered
//   in_ready : feeder idle and able to accept a pair
//   in_a     : A, element (i,k) at [(i*N+k)*DATA_W +: DATA_W]
//   in_b     : B, element (k,j) at [(k*N+j)*DATA_W +: DATA_W]
//   a_row    : row-edge operands, row i at [i*DATA_W +: DATA_W]
//   b_col    : column-edge operands, col j at [j*DATA_W +: DATA_W]
//   clear    : one-cycle array accumulator clear
//   busy     : job in progress (CLEAR and STREAM)
//   done     : one-cycle pulse, array results final
//
//   Every output is a register loaded from the next-state values, so what
//   the outputs show always describes the state the FSM is currently in.
// ---------------------------------------------------------------------------
module systolic_operand_feeder
    import systolic_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*N*DATA_W-1:0] in_a,
    input  logic [N*N*DATA_W-1:0] in_b,
    output logic [N*DATA_W-1:0]   a_row,
    output logic [N*DATA_W-1:0]   b_col,
    output logic                  clear,
    output logic                  busy,
    output logic                  done
);

    localparam int             T_W    = t_w(N);
    localparam logic [T_W-1:0] T_LAST = T_W'(3 * N - 3);

    feeder_state_e state_reg;
    feeder_state_e state_next;
    logic [T_W-1:0] t_reg;
    logic [T_W-1:0] t_next;

    logic [N*N*DATA_W-1:0] a_lat_reg;
    logic [N*N*DATA_W-1:0] b_lat_reg;

    logic                in_ready_reg;
    logic                clear_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [N*DATA_W-1:0] a_row_reg;
    logic [N*DATA_W-1:0] b_col_reg;

    logic                accept;
    logic [N*DATA_W-1:0] a_sel;
    logic [N*DATA_W-1:0] b_sel;

    // in_ready_reg is only ever 1 while IDLE, so it doubles as the state
    // qualifier; in_valid in any other state is simply not looked at.
    assign accept = in_valid && in_ready_reg;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        case (state_reg)
            IDLE: begin
                t_next = '0;
                if (accept) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = STREAM;
                t_next     = '0;
            end
            STREAM: begin
                if (t_reg == T_LAST) begin
                    state_next = DONE;
                    t_next     = '0;
                end else begin
                    t_next = t_reg + T_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                t_next     = '0;
            end
            default: begin
                state_next = IDLE;
                t_next     = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Skewed lane selection. Row lane i carries A[i][*], which is contiguous
    // in the flattened bus; column lane j carries B[*][j], which has to be
    // gathered with stride N. The selectors look at t_next because their
    // result is registered into the lane outputs on the same edge.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            localparam logic [T_W-1:0] LANE = T_W'(gi);
            logic [N*DATA_W-1:0] b_ops;

            for (genvar gk = 0; gk < N; gk++) begin : g_gather
                assign b_ops[lane_lsb(gk, DATA_W) +: DATA_W] =
                    b_lat_reg[elem_lsb(gk, gi, N, DATA_W) +: DATA_W];
            end

            skew_lane_sel #(
                .N      (N),
                .DATA_W (DATA_W),
                .T_W    (T_W)
            ) u_row_sel (
                .ops  (a_lat_reg[elem_lsb(gi, 0, N, DATA_W) +: N*DATA_W]),
                .lane (LANE),
                .t    (t_next),
                .sel  (a_sel[lane_lsb(gi, DATA_W) +: DATA_W])
            );

            skew_lane_sel #(
                .N      (N),
                .DATA_W (DATA_W),
                .T_W    (T_W)
            ) u_col_sel (
                .ops  (b_ops),
                .lane (LANE),
                .t    (t_next),
                .sel  (b_sel[lane_lsb(gi, DATA_W) +: DATA_W])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State, operand latches and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            t_reg        <= '0;
            a_lat_reg    <= '0;
            b_lat_reg    <= '0;
            in_ready_reg <= 1'b0;
            clear_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            a_row_reg    <= '0;
            b_col_reg    <= '0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
            if (accept) begin
                a_lat_reg <= in_a;
                b_lat_reg <= in_b;
            end
            in_ready_reg <= (state_next == IDLE);
            clear_reg    <= (state_next == CLEAR);
            busy_reg     <= (state_next == CLEAR) || (state_next == STREAM);
            done_reg     <= (state_next == DONE);
            // Lanes are zero outside STREAM; inside STREAM the selectors
            // already return zero for the lead-in and drain steps.
            a_row_reg    <= (state_next == STREAM) ? a_sel : '0;
            b_col_reg    <= (state_next == STREAM) ? b_sel : '0;
        end
    end

    assign in_ready = in_ready_reg;
    assign clear    = clear_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign a_row    = a_row_reg;
    assign b_col    = b_col_reg;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_operand_feeder
//   Drives directed matrix pairs into the feeder, which feeds a behavioural
//   2x2 output-stationary MAC array. The driver pushes the expected lane
//   values of every stream step and the expected product matrix into
//   queues; a monitor on the falling edge pops and compares them whenever
//   the feeder presents a clear, stream or done cycle.
// ---------------------------------------------------------------------------
module tb_systolic_operand_feeder;

    localparam int N  = 2;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [15:0] a_row;
    logic [15:0] b_col;
    logic        clear;
    logic        busy;
    logic        done;

    systolic_operand_feeder #(
        .N      (N),
        .DATA_W (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .a_row    (a_row),
        .b_col    (b_col),
        .clear    (clear),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string nm, input longint act, input longint expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, expv, expv, cyc);
        end
    endtask

    // ---------------- behavioural 2x2 PE array --------------------------
    logic signed [7:0] ah [2][2];
    logic signed [7:0] bv [2][2];
    int                acc[2][2];

    function automatic logic signed [7:0] pe_a(input int i, input int j);
        if (j == 0) return a_row[i*8 +: 8];
        else        return ah[i][j-1];
    endfunction

    function automatic logic signed [7:0] pe_b(input int i, input int j);
        if (i == 0) return b_col[j*8 +: 8];
        else        return bv[i-1][j];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (!rst_n) begin
                    ah[i][j]  <= '0;
                    bv[i][j]  <= '0;
                    acc[i][j] <= 0;
                end else begin
                    ah[i][j]  <= pe_a(i, j);
                    bv[i][j]  <= pe_b(i, j);
                    acc[i][j] <= clear ? 0 : acc[i][j] + int'(pe_a(i, j)) * int'(pe_b(i, j));
                end
            end
        end
    end

    // ---------------- expectations --------------------------------------
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } lanes_t;

    typedef struct packed {
        int c00;
        int c01;
        int c10;
        int c11;
    } cexp_t;

    lanes_t lane_q[$];
    cexp_t  c_q[$];
    int     acc_q[$];

    function automatic logic [31:0] mk(input int e00, input int e01, input int e10, input int e11);
        return {8'(e11), 8'(e10), 8'(e01), 8'(e00)};
    endfunction

    // Hand-placed N=2 skew table. Element index: 0=(0,0) 1=(0,1) 2=(1,0) 3=(1,1).
    //   t0: a=(A00,0)   b=(B00,0)
    //   t1: a=(A01,A10) b=(B10,B01)
    //   t2: a=(0,A11)   b=(0,B11)
    //   t3: all zero (drain)
    // Lane 0 is the low byte of each 16-bit word.
    function automatic lanes_t exp_lanes(input logic [31:0] a, input logic [31:0] b, input int t);
        lanes_t r;
        r = '0;
        case (t)
            0: begin r.a = {8'h00, a[7:0]};    r.b = {8'h00, b[7:0]};    end
            1: begin r.a = {a[23:16], a[15:8]}; r.b = {b[15:8], b[23:16]}; end
            2: begin r.a = {a[31:24], 8'h00};   r.b = {b[31:24], 8'h00};   end
            default: r = '0;
        endcase
        return r;
    endfunction

    // ---------------- monitor -------------------------------------------
    bit     prev_clear = 1'b0;
    lanes_t me;
    cexp_t  mc;
    int     ma;

    always @(negedge clk) begin
        if (rst_n) begin
            if (clear) begin
                check({prev_clear, busy, in_ready, done, a_row, b_col} == {4'b0100, 32'h0},
                      "clear_cycle", {prev_clear, busy, in_ready, done, a_row, b_col},
                      {4'b0100, 32'h0});
            end else if (busy) begin
                if (lane_q.size() == 0) begin
                    check(1'b0, "extra_stream_cycle", 1, 0);
                end else begin
                    if (lane_q.size() == 4)
                        check(prev_clear == 1'b1, "clear_before_t0", prev_clear, 1);
                    me = lane_q.pop_front();
                    check({a_row, b_col} == me, "stream_lanes", {a_row, b_col}, me);
                    check({in_ready, done} == 2'b00, "stream_ready_done_low", {in_ready, done}, 0);
                end
            end else if (done) begin
                check({in_ready, a_row, b_col} == 33'h0, "done_cycle_outputs",
                      {in_ready, a_row, b_col}, 0);
                if (c_q.size() == 0) begin
                    check(1'b0, "unexpected_done", 1, 0);
                end else begin
                    mc = c_q.pop_front();
                    ma = acc_q.pop_front();
                    // Accept at edge E0 -> done visible after edge E5 (cycle 6).
                    check(cyc - ma == 5, "done_latency", cyc - ma, 5);
                    check(lane_q.size() == 0, "stream_length", lane_q.size(), 0);
                    check(acc[0][0] == mc.c00, "c00", acc[0][0], mc.c00);
                    check(acc[0][1] == mc.c01, "c01", acc[0][1], mc.c01);
                    check(acc[1][0] == mc.c10, "c10", acc[1][0], mc.c10);
                    check(acc[1][1] == mc.c11, "c11", acc[1][1], mc.c11);
                    $display("job done at cycle %0d: C=[[%0d,%0d],[%0d,%0d]]",
                             cyc, acc[0][0], acc[0][1], acc[1][0], acc[1][1]);
                end
            end
            prev_clear <= clear;
        end else begin
            prev_clear <= 1'b0;
        end
    end

    // ---------------- driver --------------------------------------------
    task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                           input int c00, input int c01, input int c10, input int c11,
                           input bit hold, output int acc_cyc);
        int    w;
        cexp_t e;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!in_ready && w < 100);
        check(in_ready == 1'b1, "accept_wait", in_ready, 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            acc_cyc  = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        for (int t = 0; t < 3 * N - 2; t++) lane_q.push_back(exp_lanes(a, b, t));
        e.c00 = c00; e.c01 = c01; e.c10 = c10; e.c11 = c11;
        c_q.push_back(e);
        acc_q.push_back(cyc);
        $display("job accepted at cycle %0d: A=0x%08h B=0x%08h", cyc, a, b);
        if (!hold) in_valid = 1'b0;
    endtask

    logic [31:0] m_a, m_b, m_neg, m_id, m_ext;
    int          ac1, ac2, w;

    initial begin
        m_a   = mk(1, 2, 3, 4);
        m_b   = mk(5, 6, 7, 8);
        m_neg = mk(-128, -128, -128, -128);
        m_id  = mk(1, 0, 0, 1);
        m_ext = mk(127, -128, -1, 0);

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check({in_ready, clear, busy, done, a_row, b_col} == 36'h0, "reset_outputs",
              {in_ready, clear, busy, done, a_row, b_col}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check(in_ready == 1'b1, "ready_after_reset", in_ready, 1);

        // Skew check + product [[19,22],[43,50]]
        run_job(m_a, m_b, 19, 22, 43, 50, 1'b0, ac1);
        // Signed extremes: (-128)*(-128)*2 = 32768 everywhere
        run_job(m_neg, m_neg, 32768, 32768, 32768, 32768, 1'b0, ac1);
        // A * I = A
        run_job(m_ext, m_id, 127, -128, -1, 0, 1'b0, ac1);

        // Back-to-back with in_valid held: second accept on the first IDLE
        // cycle, i.e. 7 edges after the first accept (cycles 0..7).
        run_job(m_a, m_b, 19, 22, 43, 50, 1'b1, ac1);
        run_job(m_id, m_id, 1, 0, 0, 1, 1'b0, ac2);
        check(ac2 - ac1 == 7, "b2b_accept_gap", ac2 - ac1, 7);

        // in_valid pulsed with junk data during STREAM must be ignored
        run_job(m_a, m_b, 19, 22, 43, 50, 1'b0, ac1);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = mk(9, 9, 9, 9);
        in_b     = mk(-9, -9, -9, -9);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;

        // Reset at STREAM t=1: everything drops, no done, then a clean job
        run_job(m_a, m_b, 19, 22, 43, 50, 1'b0, ac1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({in_ready, clear, busy, done, a_row, b_col} == 36'h0, "reset_midstream",
              {in_ready, clear, busy, done, a_row, b_col}, 0);
        lane_q.delete();
        c_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check(in_ready == 1'b1, "ready_after_midreset", in_ready, 1);
        run_job(m_neg, m_id, -128, -128, -128, -128, 1'b0, ac1);

        // Wait for all outstanding results
        w = 0;
        while (c_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check(c_q.size() == 0, "drain_wait", c_q.size(), 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
